// File: rtl/ddr3_ref_arb_if.sv
// rtl/ddr3_ref_arb_if.sv - configurator, controller and DDL command ports of the refresh arbiter
interface ddr3_ref_arb_if #(
   parameter int DDR_ROW_BITS = 13
);
   logic                    cfg_run_i;
   logic                    cfg_req_i;
   logic                    cfg_rdy_o;
   logic [2:0]              cfg_cmd_i;
   logic [2:0]              cfg_ba_i;
   logic [DDR_ROW_BITS-1:0] cfg_adr_i;
   logic                    cfg_ref_i;
   logic                    mem_req_i;
   logic                    mem_seq_i;
   logic                    mem_rdy_o;
   logic [2:0]              mem_cmd_i;
   logic [2:0]              mem_ba_i;
   logic [DDR_ROW_BITS-1:0] mem_adr_i;
   logic                    mem_ref_o;
   logic                    ddl_req_o;
   logic                    ddl_seq_o;
   logic                    ddl_rdy_i;
   logic [2:0]              ddl_cmd_o;
   logic [2:0]              ddl_ba_o;
   logic [DDR_ROW_BITS-1:0] ddl_adr_o;
   logic [3:0]              ref_cnt_o;
   logic                    ref_err_o;

   modport master (
      output cfg_run_i, cfg_req_i, cfg_cmd_i, cfg_ba_i, cfg_adr_i, cfg_ref_i,
      output mem_req_i, mem_seq_i, mem_cmd_i, mem_ba_i, mem_adr_i, ddl_rdy_i,
      input  cfg_rdy_o, mem_rdy_o, mem_ref_o, ddl_req_o, ddl_seq_o,
      input  ddl_cmd_o, ddl_ba_o, ddl_adr_o, ref_cnt_o, ref_err_o
   );

   modport slave (
      input  cfg_run_i, cfg_req_i, cfg_cmd_i, cfg_ba_i, cfg_adr_i, cfg_ref_i,
      input  mem_req_i, mem_seq_i, mem_cmd_i, mem_ba_i, mem_adr_i, ddl_rdy_i,
      output cfg_rdy_o, mem_rdy_o, mem_ref_o, ddl_req_o, ddl_seq_o,
      output ddl_cmd_o, ddl_ba_o, ddl_adr_o, ref_cnt_o, ref_err_o
   );
endinterface

// File: rtl/ddr3_ref_arb.sv
// rtl/ddr3_ref_arb.sv - DDR3 command arbiter inserting PRECHARGE-ALL + REFRESH between controller sequences
module ddr3_ref_arb #(
   parameter int DDR_ROW_BITS = 13,
   parameter int REF_MAX      = 8,
   parameter int REF_URGENT   = 4
) (
   input logic           clock,
   input logic           reset,
   ddr3_ref_arb_if.slave bus
);
   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_PREC = 2'd2;
   localparam logic [1:0] ST_REFR = 2'd3;

   localparam logic [2:0] CMD_REFR = 3'b001;
   localparam logic [2:0] CMD_PREC = 3'b010;
   localparam logic [2:0] CMD_NOOP = 3'b111;

   localparam logic [3:0] CNT_MAX = 4'(REF_MAX);
   localparam logic [3:0] CNT_URG = 4'(REF_URGENT);

   logic [1:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       lock, err, mem_ref;
   logic       start, tick, ref_acc, mem_acc;

   always_comb begin
      start   = (state == ST_IDLE) && (cnt != '0) && !lock && (!bus.mem_req_i || cnt == CNT_MAX);
      tick    = bus.cfg_ref_i && (state != ST_INIT);
      ref_acc = (state == ST_REFR) && bus.ddl_rdy_i;
      mem_acc = (state == ST_IDLE) && !start && bus.mem_req_i && bus.ddl_rdy_i;
   end

   // A tick and an accepted REFR in the same cycle cancel; at saturation the tick is lost.
   always_comb begin
      cnt_nxt = cnt;
      if (tick && !ref_acc && cnt != CNT_MAX)
         cnt_nxt = cnt + 4'd1;
      else if (!tick && ref_acc)
         cnt_nxt = cnt - 4'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (bus.cfg_run_i) state_nxt = ST_IDLE;
         ST_IDLE: if (start) state_nxt = ST_PREC;
         ST_PREC: if (bus.ddl_rdy_i) state_nxt = ST_REFR;
         default: if (bus.ddl_rdy_i)
                     state_nxt = (cnt_nxt != '0 && !bus.mem_req_i) ? ST_REFR : ST_IDLE;
      endcase
   end

   always_comb begin
      bus.ddl_req_o = 1'b0;
      bus.ddl_seq_o = 1'b0;
      bus.ddl_cmd_o = CMD_NOOP;
      bus.ddl_ba_o  = '0;
      bus.ddl_adr_o = '0;
      bus.cfg_rdy_o = 1'b0;
      bus.mem_rdy_o = 1'b0;
      if (!reset) begin
         case (state)
            ST_INIT: begin
               bus.ddl_req_o = bus.cfg_req_i;
               bus.ddl_cmd_o = bus.cfg_cmd_i;
               bus.ddl_ba_o  = bus.cfg_ba_i;
               bus.ddl_adr_o = bus.cfg_adr_i;
               bus.cfg_rdy_o = bus.ddl_rdy_i;
            end
            ST_IDLE: begin
               bus.ddl_req_o = bus.mem_req_i && !start;
               bus.ddl_seq_o = bus.mem_seq_i;
               bus.ddl_cmd_o = bus.mem_cmd_i;
               bus.ddl_ba_o  = bus.mem_ba_i;
               bus.ddl_adr_o = bus.mem_adr_i;
               bus.mem_rdy_o = bus.ddl_rdy_i && !start;
            end
            ST_PREC: begin
               bus.ddl_req_o     = 1'b1;
               bus.ddl_seq_o     = 1'b1;
               bus.ddl_cmd_o     = CMD_PREC;
               bus.ddl_adr_o[10] = 1'b1;
            end
            default: begin
               bus.ddl_req_o = 1'b1;
               bus.ddl_cmd_o = CMD_REFR;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_INIT;
         cnt     <= '0;
         err     <= 1'b0;
         mem_ref <= 1'b0;
         lock    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         mem_ref <= (cnt_nxt >= CNT_URG);
         if (tick && !ref_acc && cnt == CNT_MAX)
            err <= 1'b1;
         if (mem_acc)
            lock <= bus.mem_seq_i;
      end
   end

   assign bus.ref_cnt_o = cnt;
   assign bus.ref_err_o = err;
   assign bus.mem_ref_o = mem_ref;
endmodule

// File: tb/tb_ddr3_ref_arb.sv
// tb/tb_ddr3_ref_arb.sv - scoreboard bench for ddr3_ref_arb
module tb_ddr3_ref_arb;
   typedef struct packed {
      logic [2:0]  cmd;
      logic [2:0]  ba;
      logic [12:0] adr;
      logic        seq;
   } xfer_t;

   logic  clock = 1'b0;
   logic  reset = 1'b1;
   int    tests = 0;
   int    fails = 0;
   xfer_t sb[$];

   ddr3_ref_arb_if #(.DDR_ROW_BITS(13)) bus ();
   ddr3_ref_arb #(.DDR_ROW_BITS(13), .REF_MAX(8), .REF_URGENT(4)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic push(input logic [2:0] cmd, input logic [2:0] ba, input logic [12:0] adr, input logic seq);
      xfer_t e;
      e.cmd = cmd; e.ba = ba; e.adr = adr; e.seq = seq;
      sb.push_back(e);
   endtask

   task automatic mem_drive(input logic req, input logic [2:0] cmd, input logic [2:0] ba,
                            input logic [12:0] adr, input logic seq);
      bus.mem_req_i = req; bus.mem_cmd_i = cmd; bus.mem_ba_i = ba;
      bus.mem_adr_i = adr; bus.mem_seq_i = seq;
   endtask

   // Every accepted DDL transfer must match the next expected one in order.
   always @(negedge clock) begin
      xfer_t got, e;
      if (!reset && bus.ddl_req_o && bus.ddl_rdy_i) begin
         got = {bus.ddl_cmd_o, bus.ddl_ba_o, bus.ddl_adr_o, bus.ddl_seq_o};
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL xfer_unexpected: got %h expected none", got);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               fails++;
               $display("FAIL xfer: got %h expected %h", got, e);
            end
         end
      end
   end

   initial begin
      bus.cfg_run_i = 1'b0; bus.cfg_req_i = 1'b1; bus.cfg_cmd_i = 3'b000;
      bus.cfg_ba_i = 3'd0; bus.cfg_adr_i = 13'h0; bus.cfg_ref_i = 1'b0;
      bus.ddl_rdy_i = 1'b1;
      mem_drive(1'b0, 3'b111, 3'd0, 13'h0, 1'b0);
      idle(3);
      @(negedge clock);
      chk("rst_req", bus.ddl_req_o, 0);
      chk("rst_cmd", bus.ddl_cmd_o, 3'b111);
      chk("rst_cfg_rdy", bus.cfg_rdy_o, 0);
      chk("rst_cnt", bus.ref_cnt_o, 0);
      chk("rst_err", bus.ref_err_o, 0);
      chk("rst_mem_ref", bus.mem_ref_o, 0);
      step();

      reset = 1'b0;
      bus.cfg_ba_i = 3'd2; bus.cfg_adr_i = 13'h0120; bus.cfg_ref_i = 1'b1;
      push(3'b000, 3'd2, 13'h0120, 1'b0);
      @(negedge clock);
      chk("init_cfg_rdy", bus.cfg_rdy_o, 1);
      chk("init_mem_rdy", bus.mem_rdy_o, 0);
      step();
      bus.cfg_req_i = 1'b0; bus.cfg_cmd_i = 3'b111; bus.cfg_ref_i = 1'b0; bus.cfg_run_i = 1'b1;
      @(negedge clock);
      chk("init_tick_ignored", bus.ref_cnt_o, 0);
      step();

      // single refresh from idle
      bus.cfg_ref_i = 1'b1;
      push(3'b010, 3'd0, 13'h0400, 1'b1);
      push(3'b001, 3'd0, 13'h0000, 1'b0);
      step();
      bus.cfg_ref_i = 1'b0;
      @(negedge clock);
      chk("single_cnt1", bus.ref_cnt_o, 1);
      chk("single_start_gap", bus.ddl_req_o, 0);
      idle(3);
      @(negedge clock);
      chk("single_cnt0", bus.ref_cnt_o, 0);
      chk("single_idle_req", bus.ddl_req_o, 0);
      step();

      // sequence protection
      mem_drive(1'b1, 3'b011, 3'd1, 13'h0055, 1'b1);
      push(3'b011, 3'd1, 13'h0055, 1'b1);
      step();
      mem_drive(1'b0, 3'b111, 3'd0, 13'h0, 1'b0);
      bus.cfg_ref_i = 1'b1;
      step();
      bus.cfg_ref_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("lock_hold_%0d", i), bus.ddl_req_o, 0);
         step();
      end
      mem_drive(1'b1, 3'b100, 3'd1, 13'h0010, 1'b0);
      push(3'b100, 3'd1, 13'h0010, 1'b0);
      push(3'b010, 3'd0, 13'h0400, 1'b1);
      push(3'b001, 3'd0, 13'h0000, 1'b0);
      @(negedge clock);
      chk("lock_writ_rdy", bus.mem_rdy_o, 1);
      step();
      mem_drive(1'b0, 3'b111, 3'd0, 13'h0, 1'b0);
      idle(4);
      @(negedge clock);
      chk("lock_cnt0", bus.ref_cnt_o, 0);
      step();

      // urgency and preemption
      mem_drive(1'b1, 3'b011, 3'd2, 13'h0077, 1'b1);
      push(3'b011, 3'd2, 13'h0077, 1'b1);
      step();
      mem_drive(1'b0, 3'b111, 3'd0, 13'h0, 1'b0);
      bus.cfg_ref_i = 1'b1;
      idle(4);
      bus.cfg_ref_i = 1'b0;
      mem_drive(1'b1, 3'b100, 3'd2, 13'h0020, 1'b0);
      push(3'b100, 3'd2, 13'h0020, 1'b0);
      @(negedge clock);
      chk("urg_cnt4", bus.ref_cnt_o, 4);
      chk("urg_mem_ref", bus.mem_ref_o, 1);
      step();
      mem_drive(1'b1, 3'b101, 3'd2, 13'h0030, 1'b0);
      bus.ddl_rdy_i = 1'b0;
      bus.cfg_ref_i = 1'b1;
      idle(4);
      bus.cfg_ref_i = 1'b0;
      bus.ddl_rdy_i = 1'b1;
      push(3'b010, 3'd0, 13'h0400, 1'b1);
      for (int i = 0; i < 8; i++) push(3'b001, 3'd0, 13'h0000, 1'b0);
      @(negedge clock);
      chk("pre_cnt8", bus.ref_cnt_o, 8);
      chk("pre_req_gap", bus.ddl_req_o, 0);
      chk("pre_mem_rdy", bus.mem_rdy_o, 0);
      step();
      mem_drive(1'b0, 3'b111, 3'd0, 13'h0, 1'b0);
      step();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         chk($sformatf("burst_cnt_%0d", i), bus.ref_cnt_o, 9 - i);
         chk($sformatf("burst_mem_ref_%0d", i), bus.mem_ref_o, (9 - i >= 4) ? 1 : 0);
         step();
      end
      @(negedge clock);
      chk("burst_cnt0", bus.ref_cnt_o, 0);
      chk("burst_idle_req", bus.ddl_req_o, 0);
      step();

      // tick coinciding with an accepted REFR
      bus.ddl_rdy_i = 1'b0;
      bus.cfg_ref_i = 1'b1;
      idle(2);
      bus.cfg_ref_i = 1'b0;
      @(negedge clock);
      chk("sim_cnt2", bus.ref_cnt_o, 2);
      chk("sim_prec_wait", bus.ddl_req_o, 1);
      step();
      bus.ddl_rdy_i = 1'b1;
      push(3'b010, 3'd0, 13'h0400, 1'b1);
      for (int i = 0; i < 3; i++) push(3'b001, 3'd0, 13'h0000, 1'b0);
      step();
      bus.cfg_ref_i = 1'b1;
      step();
      bus.cfg_ref_i = 1'b0;
      @(negedge clock);
      chk("sim_cnt_kept", bus.ref_cnt_o, 2);
      idle(3);
      @(negedge clock);
      chk("sim_cnt0", bus.ref_cnt_o, 0);
      step();

      // saturation, sticky error, reset while in PREC
      bus.ddl_rdy_i = 1'b0;
      bus.cfg_ref_i = 1'b1;
      idle(9);
      bus.cfg_ref_i = 1'b0;
      @(negedge clock);
      chk("sat_cnt", bus.ref_cnt_o, 8);
      chk("sat_err", bus.ref_err_o, 1);
      chk("sat_prec_req", bus.ddl_req_o, 1);
      chk("sat_prec_cmd", bus.ddl_cmd_o, 3'b010);
      idle(3);
      @(negedge clock);
      chk("sat_err_sticky", bus.ref_err_o, 1);
      step();
      reset = 1'b1;
      @(negedge clock);
      chk("rst_prec_req", bus.ddl_req_o, 0);
      step();
      reset = 1'b0;
      bus.ddl_rdy_i = 1'b1;
      bus.cfg_req_i = 1'b1; bus.cfg_cmd_i = 3'b110; bus.cfg_ba_i = 3'd0; bus.cfg_adr_i = 13'h0400;
      push(3'b110, 3'd0, 13'h0400, 1'b0);
      @(negedge clock);
      chk("post_rst_init_rdy", bus.cfg_rdy_o, 1);
      chk("post_rst_cnt", bus.ref_cnt_o, 0);
      chk("post_rst_err", bus.ref_err_o, 0);
      step();
      bus.cfg_req_i = 1'b0; bus.cfg_cmd_i = 3'b111;
      idle(3);
      @(negedge clock);
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ddr3_ref_arb.md
# ddr3_ref_arb

Command arbiter and refresh scheduler between the DDR3 configurator (`ddr3_cfg`), the memory-controller FSM (`ddr3_fsm`) and the DFI delay/latency stage (`ddr3_ddl`). During initialisation it passes configurator commands straight through. Once initialisation completes, it switches to the controller port, counts refresh ticks from the configurator and inserts PRECHARGE-ALL + REFRESH sequences between controller command sequences, never inside one. It replaces ad-hoc refresh muxing at the top level.

## Interface
Parameters:
- `DDR_ROW_BITS`, 13: DDR3 row/address width (`RSB = DDR_ROW_BITS-1`).
- `REF_MAX`, 8: maximum postponed refreshes (JEDEC limit); pending count saturates here.
- `REF_URGENT`, 4: pending count at or above which `mem_ref_o` is asserted.

Ports:
- `clock`  in  1: single system clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `cfg_run_i`  in  1: initialisation complete; level, rises once.
- `cfg_req_i`  in  1: configurator command request.
- `cfg_rdy_o`  out  1: configurator command accepted.
- `cfg_cmd_i`  in  3: configurator command, {ras_n,cas_n,we_n}.
- `cfg_ba_i`  in  3: configurator bank address.
- `cfg_adr_i`  in  `DDR_ROW_BITS`: configurator address.
- `cfg_ref_i`  in  1: one-cycle refresh tick (one per tREFI).
- `mem_req_i`  in  1: controller command request.
- `mem_seq_i`  in  1: more commands of the same atomic sequence follow.
- `mem_rdy_o`  out  1: controller command accepted.
- `mem_cmd_i`  in  3: controller command.
- `mem_ba_i`  in  3: controller bank address.
- `mem_adr_i`  in  `DDR_ROW_BITS`: controller address.
- `mem_ref_o`  out  1: refresh urgent; controller should close its sequence.
- `ddl_req_o`  out  1: command request to the DDL.
- `ddl_seq_o`  out  1: sequence-continues flag to the DDL.
- `ddl_rdy_i`  in  1: DDL accepts the command.
- `ddl_cmd_o`  out  3: command to the DDL.
- `ddl_ba_o`  out  3: bank address to the DDL.
- `ddl_adr_o`  out  `DDR_ROW_BITS`: address to the DDL.
- `ref_cnt_o`  out  4: pending refresh count.
- `ref_err_o`  out  1: sticky; a tick arrived while the count was at `REF_MAX`.

## Operation
Command encoding: MRS=000, REFR=001, PREC=010, ACTV=011, WRIT=100, READ=101, ZQCL=110, NOOP=111. A command transfers on any cycle where `ddl_req_o && ddl_rdy_i`.

States:
- **ST_INIT** (reset state):
  - `ddl_*` mirror `cfg_*` combinationally, with `ddl_seq_o=0`.
  - `cfg_rdy_o = ddl_rdy_i`; `mem_rdy_o = 0`.
  - `cfg_ref_i` is ignored.
  - Exit to ST_IDLE on the first cycle `cfg_run_i=1`.
- **ST_IDLE**:
  - `ddl_*` mirror `mem_*` combinationally; `mem_rdy_o = ddl_rdy_i`; `cfg_rdy_o = 0`.
  - Register `lock`: set on an accepted controller command with `mem_seq_i=1`; cleared on an accepted one with `mem_seq_i=0`.
  - `start = (ref_cnt_o != 0) && !lock && (!mem_req_i || ref_cnt_o == REF_MAX)`.
  - When `start=1`: force `ddl_req_o=0` and `mem_rdy_o=0` that cycle, and go to ST_PREC.
- **ST_PREC**:
  - Registered outputs: `ddl_req_o=1`, cmd=PREC, `adr[10]=1` (all banks), other address bits 0, ba=0, `ddl_seq_o=1`.
  - On accept, go to ST_REFR.
- **ST_REFR**:
  - Registered outputs: `ddl_req_o=1`, cmd=REFR, ba=0, adr=0, `ddl_seq_o=0`.
  - On accept, decrement the pending count.
  - Next state: ST_REFR again if (count after decrement) > 0 and `mem_req_i=0`; otherwise ST_IDLE.
- Pending counter (ST_IDLE/PREC/REFR only):
  - A tick increments it; an accepted REFR decrements it.
  - A tick in the same cycle as an accepted REFR leaves it unchanged.
  - A tick while the count is `REF_MAX` (and no REFR accepted that cycle) keeps the count at `REF_MAX` and sets `ref_err_o`.
- `mem_ref_o = (ref_cnt_o >= REF_URGENT)`, registered.
- While `mem_rdy_o=0`, controller inputs are held by the controller per the req/rdy protocol; this block does not buffer them.

## Timing
- Reset values:
  - State ST_INIT; `ref_cnt_o=0`, `ref_err_o=0`, `mem_ref_o=0`, `lock=0`.
  - While `reset=1`: `ddl_req_o=0`, `ddl_cmd_o=NOOP`, `ddl_seq_o=0`, `ddl_ba_o=0`, `ddl_adr_o=0`, `cfg_rdy_o=0`, `mem_rdy_o=0`.
- Pass-through (ST_INIT, ST_IDLE): zero-cycle combinational latency from request to `ddl_req_o` and from `ddl_rdy_i` to the port's rdy.
- Refresh insertion: PREC is requested on the cycle after `start`. REFR is requested on the cycle after PREC is accepted.
- Minimum idle-to-REFR issue is 3 cycles when `ddl_rdy_i` is held high. The DDL enforces tRP/tRFC by withholding `ddl_rdy_i`.
- Reset mid-sequence: an abandoned PREC/REFR is dropped, the count is cleared, and the block returns to ST_INIT.

## Test plan
- Init pass-through: `cfg_req_i=1`, cmd=MRS (000), ba=2, adr=0x0120, `ddl_rdy_i=1` → same values on `ddl_*` that cycle, `cfg_rdy_o=1`, `mem_rdy_o=0`. A tick during init leaves `ref_cnt_o=0`.
- Single refresh: `cfg_run_i=1`, controller idle, one tick, `ddl_rdy_i=1` →
  - `ref_cnt_o=1` on the next cycle;
  - then PREC with `adr=0x0400`, `ddl_seq_o=1`, then REFR;
  - `ref_cnt_o=0`, back to ST_IDLE.
- Sequence protection: accept ACTV with `mem_seq_i=1`, then inject a tick → no PREC until WRIT with `mem_seq_i=0` is accepted. The refresh is issued afterwards, with no controller command between PREC and REFR.
- Urgency/priority: 4 ticks while `lock=1` → `mem_ref_o=1`. Raise the count to 8 with `mem_req_i` held high and `lock=0` → refresh preempts; 8 back-to-back REFRs after one PREC; `mem_ref_o` falls once the count is below 4.
- Saturation: 9 ticks with `ddl_rdy_i=0` → `ref_cnt_o=8`, `ref_err_o=1` sticky until reset.
- Simultaneous events: a tick on the same cycle as an accepted REFR with count 2 → count stays 2. Reset asserted in ST_PREC → `ddl_req_o=0` the next cycle and state ST_INIT.
